word_mux_arb: RTL



---
 rtl/word_mux_arb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/word_mux_arb.sv
// word_mux_arb: 8:1 round-robin word multiplexer with one registered output.
// Optional out_src tag port when WORD_MUX_ARB_SRC_TAG_EN is defined.
module word_mux_arb #(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_IN     = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*WORD_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  output logic [WORD_WIDTH-1:0]        out_data,
`ifdef WORD_MUX_ARB_SRC_TAG_EN
  output logic [2:0]                   out_src,
`endif
  input  logic                         out_ready
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [2:0]            last_q, last_d;
`ifdef WORD_MUX_ARB_SRC_TAG_EN
  logic [2:0]            src_q, src_d;
`endif

  logic                  can_load;
  logic                  found;
  logic [2:0]            grant;
  logic [2:0]            idx;
  logic                  accept;
  logic [WORD_WIDTH-1:0] word_g;

  // The holding register can take a word when empty or being drained now.
  assign can_load = (state_q == S_EMPTY) | out_ready;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found = 1'b0;
    grant = 3'd0;
    idx   = 3'd0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = last_q + k[2:0];
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Select the granted channel's word.
  always_comb begin
    word_g = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == i[2:0]) begin
        word_g = in_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // No grant is offered while reset is held.
  assign accept = found & can_load & nrst;

  // One-hot grant toward the winning producer.
  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Next-state and register-load logic for the holding register.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef WORD_MUX_ARB_SRC_TAG_EN
    src_d   = src_q;
`endif
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (out_ready && !accept) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      data_d = word_g;
      last_d = grant;
`ifdef WORD_MUX_ARB_SRC_TAG_EN
      src_d  = grant;
`endif
    end
  end

  // State and data registers; pointer resets to 7 so channel 0 wins first.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      last_q  <= 3'd7;
`ifdef WORD_MUX_ARB_SRC_TAG_EN
      src_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef WORD_MUX_ARB_SRC_TAG_EN
      src_q   <= src_d;
`endif
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_data  = data_q;
`ifdef WORD_MUX_ARB_SRC_TAG_EN
  assign out_src   = src_q;
`endif

endmodule
